// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
// Build option RST_SEQ_TIMEOUT_EN is consumed by reset_seq_ctrl.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        HOLD     = 3'd0,
        DELAY    = 3'd1,
        RELEASE  = 3'd2,
        WAIT_ACK = 3'd3,
        DONE     = 3'd4
    } rst_seq_state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchroniser: asserts asynchronously, deasserts after STAGES clock edges.
module rst_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync_n
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = sync_q[STAGES-1];

endmodule

// File: rtl/reset_seq_ctrl.sv
// Staggered reset-release sequencer for NUM_DOM async-reset domains.
// Define RST_SEQ_TIMEOUT_EN to add the sticky ack-timeout flag on err.
module reset_seq_ctrl
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_DOM     = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DLY_W       = 8,
    parameter int unsigned HOLD_CYC    = 16,
    parameter int unsigned TMO_CYC     = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sw_rst_req,
    input  logic [NUM_DOM*DLY_W-1:0] dly_cfg,
    input  logic [NUM_DOM-1:0]       dom_ack,
    output logic [NUM_DOM-1:0]       rst_out_n,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int unsigned IDX_W = idx_w(NUM_DOM);
    localparam int unsigned CNT_W = max_u(DLY_W, max_u(idx_w(HOLD_CYC), idx_w(TMO_CYC)));
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOM - 1);

    logic                 sync_rst_n;
    rst_seq_state_t       state, state_d;
    logic [IDX_W-1:0]     idx, idx_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [NUM_DOM-1:0]   rst_out_n_d;
    logic                 busy_d;
    logic                 done_d;
    logic                 ack_go;
    logic [DLY_W-1:0]     dly_arr [NUM_DOM];

    rst_sync #(
        .STAGES     (SYNC_STAGES)
    ) u_rst_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rst_sync_n (sync_rst_n)
    );

    for (genvar g = 0; g < NUM_DOM; g++) begin : g_dly
        assign dly_arr[g] = dly_cfg[g*DLY_W +: DLY_W];
    end

`ifdef RST_SEQ_TIMEOUT_EN
    logic tmo_hit;
    logic err_d;
`endif

    // Next-state and next-output logic; a software request overrides everything but err.
    always_comb begin
        state_d     = state;
        idx_d       = idx;
        cnt_d       = cnt;
        rst_out_n_d = rst_out_n;
        busy_d      = 1'b1;
        done_d      = 1'b0;
        ack_go      = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
        tmo_hit     = 1'b0;
        err_d       = err;
`endif
        unique case (state)
            HOLD: begin
                rst_out_n_d = '0;
                idx_d       = '0;
                if (cnt == CNT_W'(HOLD_CYC - 1)) begin
                    cnt_d   = CNT_W'(dly_arr[0]);
                    state_d = DELAY;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DELAY: begin
                if (cnt == '0) begin
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            RELEASE: begin
                rst_out_n_d[idx] = 1'b1;
                cnt_d            = '0;
                state_d          = WAIT_ACK;
            end
            WAIT_ACK: begin
`ifdef RST_SEQ_TIMEOUT_EN
                // A timeout is treated as an ack but leaves err set.
                tmo_hit = !dom_ack[idx] && (cnt == CNT_W'(TMO_CYC - 1));
                err_d   = err | tmo_hit;
                cnt_d   = cnt + CNT_W'(1);
                ack_go  = dom_ack[idx] || tmo_hit;
`else
                ack_go  = dom_ack[idx];
`endif
                if (ack_go) begin
                    if (idx == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx + IDX_W'(1);
                        cnt_d   = CNT_W'(dly_arr[idx + IDX_W'(1)]);
                        state_d = DELAY;
                    end
                end
            end
            DONE: begin
                rst_out_n_d = '1;
                busy_d      = 1'b0;
                done_d      = 1'b1;
            end
            default: begin
                state_d = HOLD;
            end
        endcase

        if (sw_rst_req) begin
            state_d     = HOLD;
            idx_d       = '0;
            cnt_d       = '0;
            rst_out_n_d = '0;
            busy_d      = 1'b1;
            done_d      = 1'b0;
        end
    end

    // State and output registers, cleared asynchronously whenever rst_n drops.
    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            state     <= HOLD;
            idx       <= '0;
            cnt       <= '0;
            rst_out_n <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            cnt       <= cnt_d;
            rst_out_n <= rst_out_n_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

`ifdef RST_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            err <= 1'b0;
        end else begin
            err <= err_d;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
